// File: rtl/data_path_pkg.sv
// Shared constants for the single-bus datapath: data width and ALU opcode encodings.
package data_path_pkg;

  localparam int DP_WIDTH = 32;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

endpackage

// File: rtl/data_path_alu.sv
// Combinational ALU: A comes from Y, B from the bus; 64-bit result with unused bits zero.
module data_path_alu
  import data_path_pkg::*;
#(
  parameter int WIDTH = DP_WIDTH
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [4:0]         opcode,
  input  logic               cin,
  output logic [2*WIDTH-1:0] result
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0]           amt_s;
  logic [2*WIDTH-1:0]       rot_right_s;
  logic [2*WIDTH-1:0]       rot_left_s;
  logic signed [2*WIDTH-1:0] a_ext_s;
  logic signed [2*WIDTH-1:0] b_ext_s;
  logic signed [2*WIDTH-1:0] mul_s;
  logic                     div_zero_s;
  logic                     div_neg1_s;
  logic signed [WIDTH-1:0]  a_sg_s;
  logic signed [WIDTH-1:0]  div_b_s;
  logic signed [WIDTH-1:0]  quot_s;
  logic signed [WIDTH-1:0]  rem_s;
  logic [WIDTH-1:0]         cin_ext_s;

  assign amt_s       = b[SHW-1:0];
  assign rot_right_s = {a, a} >> amt_s;
  assign rot_left_s  = {a, a} << amt_s;
  assign a_ext_s     = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_ext_s     = {{WIDTH{b[WIDTH-1]}}, b};
  assign mul_s       = a_ext_s * b_ext_s;
  assign a_sg_s      = a;
  assign cin_ext_s   = {{(WIDTH-1){1'b0}}, cin};

  // Divisor is forced to 1 for /0 and /-1 so the divider never sees an overflowing case.
  assign div_zero_s  = (b == {WIDTH{1'b0}});
  assign div_neg1_s  = (b == {WIDTH{1'b1}});
  assign div_b_s     = (div_zero_s || div_neg1_s) ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
  assign quot_s      = a_sg_s / div_b_s;
  assign rem_s       = a_sg_s % div_b_s;

  // Operation select; Cin is only referenced by ADD and SUB.
  always_comb begin
    result = {(2*WIDTH){1'b0}};
    case (opcode)
      OP_ADD:  result[WIDTH-1:0] = a + b + cin_ext_s;
      OP_SUB:  result[WIDTH-1:0] = a - b - cin_ext_s;
      OP_AND:  result[WIDTH-1:0] = a & b;
      OP_OR:   result[WIDTH-1:0] = a | b;
      OP_ROR:  result[WIDTH-1:0] = rot_right_s[WIDTH-1:0];
      OP_ROL:  result[WIDTH-1:0] = rot_left_s[2*WIDTH-1:WIDTH];
      OP_SHR:  result[WIDTH-1:0] = a >> amt_s;
      OP_SHRA: result[WIDTH-1:0] = a_sg_s >>> amt_s;
      OP_SHL:  result[WIDTH-1:0] = a << amt_s;
      OP_DIV: begin
        if (div_zero_s) begin
          result = {(2*WIDTH){1'b0}};
        end else if (div_neg1_s) begin
          result[WIDTH-1:0] = ~a + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
          result = {rem_s, quot_s};
        end
      end
      OP_MUL:  result = mul_s;
      OP_NEG:  result[WIDTH-1:0] = ~b + {{(WIDTH-1){1'b0}}, 1'b1};
      OP_NOT:  result[WIDTH-1:0] = ~b;
      default: result = {(2*WIDTH){1'b0}};
    endcase
  end

endmodule

// File: rtl/data_path.sv
// Single-bus CPU datapath: register file, PC/IR/MAR/MDR, HI/LO, Y, 64-bit Z and ALU,
// all moves crossing one shared bus steered by priority-encoded out strobes.
module data_path
  import data_path_pkg::*;
#(
  parameter int WIDTH = DP_WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             PCout,
  input  logic             Zhighout,
  input  logic             Zlowout,
  input  logic             MDRout,
  input  logic             R0out,
  input  logic             R1out,
  input  logic             R2out,
  input  logic             R3out,
  input  logic             R4out,
  input  logic             R5out,
  input  logic             R6out,
  input  logic             R7out,
  input  logic             MARin,
  input  logic             PCin,
  input  logic             MDRin,
  input  logic             IRin,
  input  logic             Yin,
  input  logic             R0in,
  input  logic             R1in,
  input  logic             R2in,
  input  logic             R3in,
  input  logic             R4in,
  input  logic             R5in,
  input  logic             R6in,
  input  logic             R7in,
  input  logic             R8in,
  input  logic             R9in,
  input  logic             R10in,
  input  logic             R11in,
  input  logic             R12in,
  input  logic             R13in,
  input  logic             R14in,
  input  logic             R15in,
  input  logic             HIin,
  input  logic             LOin,
  input  logic             ZHighIn,
  input  logic             ZLowIn,
  input  logic             IncPC,
  input  logic             Read,
  input  logic             Cin,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] Mdatain,
  output logic [WIDTH-1:0] BusMuxOut,
  output logic [WIDTH-1:0] IR_q,
  output logic [WIDTH-1:0] MAR_q
);

  logic [WIDTH-1:0]   gpr_r [16];
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic [WIDTH-1:0]   pc_r;
  logic [WIDTH-1:0]   ir_r;
  logic [WIDTH-1:0]   mar_r;
  logic [WIDTH-1:0]   mdr_r;
  logic [WIDTH-1:0]   y_r;
  logic [2*WIDTH-1:0] z_r;

  logic [WIDTH-1:0]   bus_s;
  logic [2*WIDTH-1:0] alu_result_s;
  logic [7:0]         rout_s;
  logic [15:0]        rin_s;
  logic               unused_regs_s;

  assign rout_s = {R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
  assign rin_s  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                   R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};

  // HI, LO and R8-R15 have no bus driver; they are loaded but never observed here.
  assign unused_regs_s = ^{hi_r, lo_r, gpr_r[8], gpr_r[9], gpr_r[10], gpr_r[11],
                           gpr_r[12], gpr_r[13], gpr_r[14], gpr_r[15]};

  // Bus source priority: MDR, PC, Z high, Z low, then lowest-numbered general register.
  always_comb begin
    bus_s = {WIDTH{1'b0}};
    if (MDRout == 1'b1) begin
      bus_s = mdr_r;
    end else if (PCout == 1'b1) begin
      bus_s = pc_r;
    end else if (Zhighout == 1'b1) begin
      bus_s = z_r[2*WIDTH-1:WIDTH];
    end else if (Zlowout == 1'b1) begin
      bus_s = z_r[WIDTH-1:0];
    end else begin
      casez (rout_s)
        8'b???????1: bus_s = gpr_r[0];
        8'b??????10: bus_s = gpr_r[1];
        8'b?????100: bus_s = gpr_r[2];
        8'b????1000: bus_s = gpr_r[3];
        8'b???10000: bus_s = gpr_r[4];
        8'b??100000: bus_s = gpr_r[5];
        8'b?1000000: bus_s = gpr_r[6];
        8'b10000000: bus_s = gpr_r[7];
        default:     bus_s = {WIDTH{1'b0}};
      endcase
    end
  end

  data_path_alu #(.WIDTH(WIDTH)) u_alu (
    .a      (y_r),
    .b      (bus_s),
    .opcode (opcode),
    .cin    (Cin),
    .result (alu_result_s)
  );

  // Register loads from the bus, memory data or ALU result.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < 16; i++) gpr_r[i] <= {WIDTH{1'b0}};
      hi_r  <= {WIDTH{1'b0}};
      lo_r  <= {WIDTH{1'b0}};
      pc_r  <= {WIDTH{1'b0}};
      ir_r  <= {WIDTH{1'b0}};
      mar_r <= {WIDTH{1'b0}};
      mdr_r <= {WIDTH{1'b0}};
      y_r   <= {WIDTH{1'b0}};
      z_r   <= {(2*WIDTH){1'b0}};
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (rin_s[i]) gpr_r[i] <= bus_s;
      end
      if (HIin)    hi_r  <= bus_s;
      if (LOin)    lo_r  <= bus_s;
      if (IRin)    ir_r  <= bus_s;
      if (MARin)   mar_r <= bus_s;
      if (Yin)     y_r   <= bus_s;
      if (MDRin)   mdr_r <= Read ? Mdatain : bus_s;
      if (ZHighIn) z_r[2*WIDTH-1:WIDTH] <= alu_result_s[2*WIDTH-1:WIDTH];
      if (ZLowIn)  z_r[WIDTH-1:0]       <= alu_result_s[WIDTH-1:0];
      if (PCin) begin
        pc_r <= bus_s;
      end else if (IncPC) begin
        pc_r <= pc_r + {{(WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  assign BusMuxOut = bus_s;
  assign IR_q      = ir_r;
  assign MAR_q     = mar_r;

endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path: strobe sequences with hand-computed expected values.
module tb_data_path;

  logic        clock;
  logic        clear;
  logic        PCout, Zhighout, Zlowout, MDRout;
  logic [7:0]  rout;
  logic        MARin, PCin, MDRin, IRin, Yin;
  logic [15:0] rin;
  logic        HIin, LOin, ZHighIn, ZLowIn, IncPC, Read, Cin;
  logic [4:0]  opcode;
  logic [31:0] Mdatain;
  logic [31:0] BusMuxOut, IR_q, MAR_q;

  int passed = 0;
  int total  = 0;
  logic [31:0] lo_v, hi_v;

  data_path dut (
    .clock(clock), .clear(clear),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]),
    .R4out(rout[4]), .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
    .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
    .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .HIin(HIin), .LOin(LOin), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn),
    .IncPC(IncPC), .Read(Read), .Cin(Cin), .opcode(opcode),
    .Mdatain(Mdatain), .BusMuxOut(BusMuxOut), .IR_q(IR_q), .MAR_q(MAR_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  task automatic idle();
    PCout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; rout = 8'h00;
    MARin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0; rin = 16'h0000;
    HIin = 1'b0; LOin = 1'b0; ZHighIn = 1'b0; ZLowIn = 1'b0; IncPC = 1'b0;
    Read = 1'b0; Cin = 1'b0; opcode = 5'b00000;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic load_reg(input int idx, input logic [31:0] val);
    Mdatain = val; Read = 1'b1; MDRin = 1'b1; tick();
    MDRout = 1'b1; rin[idx] = 1'b1; tick();
  endtask

  task automatic read_reg(input int idx, output logic [31:0] val);
    rout[idx] = 1'b1; #1; val = BusMuxOut; rout[idx] = 1'b0; #1;
  endtask

  task automatic alu_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                        input logic c, output logic [31:0] lo, output logic [31:0] hi);
    load_reg(1, a);
    load_reg(2, b);
    rout[1] = 1'b1; Yin = 1'b1; tick();
    rout[2] = 1'b1; opcode = op; Cin = c; ZLowIn = 1'b1; ZHighIn = 1'b1; tick();
    Zlowout = 1'b1; #1; lo = BusMuxOut; Zlowout = 1'b0;
    Zhighout = 1'b1; #1; hi = BusMuxOut; Zhighout = 1'b0; #1;
  endtask

  initial begin
    idle();
    Mdatain = 32'h0;
    clear = 1'b1;
    #3;
    check("reset_bus", BusMuxOut, 32'h0);
    check("reset_ir", IR_q, 32'h0);
    check("reset_mar", MAR_q, 32'h0);
    #4 clear = 1'b0;

    // Load path through MDR into R3
    Mdatain = 32'h0000007F; Read = 1'b1; MDRin = 1'b1; tick();
    MDRout = 1'b1; rin[3] = 1'b1; #1;
    check("xfer_bus", BusMuxOut, 32'h0000007F);
    tick();
    read_reg(3, lo_v);
    check("r3_load", lo_v, 32'h0000007F);

    // SHL R3 by R7 into R4 with Cin undriven
    load_reg(7, 32'h1);
    load_reg(4, 32'h12);
    read_reg(4, lo_v);
    check("r4_pre", lo_v, 32'h12);
    rout[3] = 1'b1; Yin = 1'b1; tick();
    rout[7] = 1'b1; opcode = 5'b01011; Cin = 1'bx; ZLowIn = 1'b1; tick();
    Zlowout = 1'b1; rin[4] = 1'b1; tick();
    read_reg(4, lo_v);
    check("shl_r4", lo_v, 32'h000000FE);

    // ALU op table
    alu_op(32'd5, 32'd7, 5'b00011, 1'b1, lo_v, hi_v);
    check("add_lo", lo_v, 32'd13);
    check("add_hi", hi_v, 32'd0);
    alu_op(32'd10, 32'd3, 5'b00100, 1'b1, lo_v, hi_v);
    check("sub_lo", lo_v, 32'd6);
    alu_op(32'hF0F0_00FF, 32'h0FF0_0F0F, 5'b00101, 1'b1, lo_v, hi_v);
    check("and_lo", lo_v, 32'h00F0_000F);
    alu_op(32'hF000_0001, 32'h0000_0F00, 5'b00110, 1'b0, lo_v, hi_v);
    check("or_lo", lo_v, 32'hF000_0F01);
    alu_op(32'h0000_0001, 32'd1, 5'b00111, 1'b0, lo_v, hi_v);
    check("ror_lo", lo_v, 32'h8000_0000);
    alu_op(32'h8000_0001, 32'd33, 5'b01000, 1'b0, lo_v, hi_v);
    check("rol_33", lo_v, 32'h0000_0003);
    alu_op(32'h8000_0010, 32'd32, 5'b01001, 1'b0, lo_v, hi_v);
    check("shr_32", lo_v, 32'h8000_0010);
    alu_op(32'h8000_0000, 32'd4, 5'b01010, 1'b0, lo_v, hi_v);
    check("shra_lo", lo_v, 32'hF800_0000);
    alu_op(32'hFFFF_FFFA, 32'd4, 5'b10000, 1'b1, lo_v, hi_v);
    check("mul_lo", lo_v, 32'hFFFF_FFE8);
    check("mul_hi", hi_v, 32'hFFFF_FFFF);
    alu_op(32'd7, 32'd2, 5'b01111, 1'b1, lo_v, hi_v);
    check("div_q", lo_v, 32'd3);
    check("div_r", hi_v, 32'd1);
    alu_op(32'hFFFF_FFF9, 32'd2, 5'b01111, 1'b0, lo_v, hi_v);
    check("divneg_q", lo_v, 32'hFFFF_FFFD);
    check("divneg_r", hi_v, 32'hFFFF_FFFF);
    alu_op(32'd9, 32'd0, 5'b01111, 1'b0, lo_v, hi_v);
    check("div0_lo", lo_v, 32'd0);
    check("div0_hi", hi_v, 32'd0);
    alu_op(32'd1, 32'd5, 5'b10001, 1'b1, lo_v, hi_v);
    check("neg_lo", lo_v, 32'hFFFF_FFFB);
    check("neg_hi", hi_v, 32'd0);
    alu_op(32'd1, 32'h0000_FFFF, 5'b10010, 1'b0, lo_v, hi_v);
    check("not_lo", lo_v, 32'hFFFF_0000);
    alu_op(32'd3, 32'd4, 5'b00000, 1'b1, lo_v, hi_v);
    check("undef_lo", lo_v, 32'd0);

    // Instruction fetch from PC=0
    PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; #1;
    check("fetch_bus", BusMuxOut, 32'h0);
    tick();
    check("fetch_mar", MAR_q, 32'h0);
    PCout = 1'b1; #1;
    check("pc_inc", BusMuxOut, 32'h1);
    idle();
    Mdatain = 32'h5A1B_8000; Read = 1'b1; MDRin = 1'b1; tick();
    MDRout = 1'b1; IRin = 1'b1; tick();
    check("fetch_ir", IR_q, 32'h5A1B_8000);

    // Bus priority and PCin over IncPC
    MDRout = 1'b1; PCout = 1'b1; #1;
    check("prio_mdr_pc", BusMuxOut, 32'h5A1B_8000);
    idle();
    rout = 8'h84; #1;
    check("prio_r2_r7", BusMuxOut, 32'd4);
    idle();
    MDRout = 1'b1; PCin = 1'b1; IncPC = 1'b1; tick();
    PCout = 1'b1; MARin = 1'b1; tick();
    check("pcin_wins", MAR_q, 32'h5A1B_8000);

    // PC wraps at 2^32
    Mdatain = 32'hFFFF_FFFF; Read = 1'b1; MDRin = 1'b1; tick();
    MDRout = 1'b1; PCin = 1'b1; tick();
    IncPC = 1'b1; tick();
    PCout = 1'b1; #1;
    check("pc_wrap", BusMuxOut, 32'h0);
    idle();

    // Clear pulsed between edges takes effect immediately
    #2 clear = 1'b1; #1;
    check("clr_ir", IR_q, 32'h0);
    check("clr_mar", MAR_q, 32'h0);
    rout[3] = 1'b1; #1;
    check("clr_r3", BusMuxOut, 32'h0);
    idle(); MDRout = 1'b1; #1;
    check("clr_mdr", BusMuxOut, 32'h0);
    idle(); Zhighout = 1'b1; #1;
    check("clr_zhi", BusMuxOut, 32'h0);
    idle();
    clear = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
